// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load-unit results into one register-file write port.
// Latency: a word accepted into an empty queue at edge k is on Write/Wn/Wd after edge k+1.
// Backpressure: valid/ready per source, one accept per cycle, ALU first with a MEM
//   anti-starvation streak; both readies drop while the queue holds DEPTH entries.
// Ports: Clock/Resetn (async active-low); Alu*/Mem* source handshakes with dst/data;
//   Write/Wn/Wd registered write port; Rn1/Rn2 -> Hit1/Hit2, Fwd1/Fwd2 bypass lookup.
// Build option: define WB_BYPASS_EN to compile in the bypass lookup (else Hit/Fwd tie to 0).
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        AluValid,
  output logic        AluReady,
  input  logic [4:0]  AluDst,
  input  logic [31:0] AluData,
  input  logic        MemValid,
  output logic        MemReady,
  input  logic [4:0]  MemDst,
  input  logic [31:0] MemData,
  output logic        Write,
  output logic [4:0]  Wn,
  output logic [31:0] Wd,
  input  logic [4:0]  Rn1,
  input  logic [4:0]  Rn2,
  output logic        Hit1,
  output logic        Hit2,
  output logic [31:0] Fwd1,
  output logic [31:0] Fwd2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]    streak_q, streak_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    fifo_dst_q [DEPTH];
  logic [4:0]    fifo_dst_d [DEPTH];
  logic [31:0]   fifo_dat_q [DEPTH];
  logic [31:0]   fifo_dat_d [DEPTH];
  logic          write_q, write_d;
  logic [4:0]    wn_q, wn_d;
  logic [31:0]   wd_q, wd_d;

  logic          full, mem_prio, alu_xfer, mem_xfer, push, pop;
  logic [4:0]    in_dst;
  logic [31:0]   in_dat;

  // Handshake and arbitration. Readies never look at the pop of the current
  // cycle, so a full queue stalls both sources for that cycle.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    mem_prio = (streak_q == 2'd3);
    AluReady = !full && (!mem_prio || !MemValid);
    MemReady = !full && (!AluValid || mem_prio);
    alu_xfer = AluValid && AluReady;
    mem_xfer = MemValid && MemReady;
    in_dst   = mem_xfer ? MemDst  : AluDst;
    in_dat   = mem_xfer ? MemData : AluData;
    // Dst 0 completes the handshake but is dropped, so Wn=0 is never written.
    push     = (alu_xfer || mem_xfer) && (in_dst != 5'd0);
    pop      = (count_q != '0);
  end

  // Next-state for streak, queue and the registered write beat.
  always_comb begin
    streak_d   = streak_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_dst_d = fifo_dst_q;
    fifo_dat_d = fifo_dat_q;
    write_d    = pop;
    wn_d       = wn_q;
    wd_d       = wd_q;

    if (mem_xfer || !MemValid) begin
      streak_d = 2'd0;
    end else if (alu_xfer && streak_q != 2'd3) begin
      streak_d = streak_q + 2'd1;
    end

    if (push) begin
      fifo_dst_d[wr_ptr_q] = in_dst;
      fifo_dat_d[wr_ptr_q] = in_dat;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      wn_d     = fifo_dst_q[rd_ptr_q];
      wd_d     = fifo_dat_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      streak_q <= 2'd0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      write_q  <= 1'b0;
      wn_q     <= 5'd0;
      wd_q     <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_dst_q[i] <= 5'd0;
        fifo_dat_q[i] <= 32'd0;
      end
    end else begin
      streak_q   <= streak_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      write_q    <= write_d;
      wn_q       <= wn_d;
      wd_q       <= wd_d;
      fifo_dst_q <= fifo_dst_d;
      fifo_dat_q <= fifo_dat_d;
    end
  end

  assign Write = write_q;
  assign Wn    = wn_q;
  assign Wd    = wd_q;

`ifdef WB_BYPASS_EN
  logic [4:0]  rn  [2];
  logic [1:0]  hit;
  logic [31:0] fwd [2];

  assign rn[0] = Rn1;
  assign rn[1] = Rn2;

  // Scan oldest to newest (write beat first, then queue from rd_ptr) so the
  // last match, i.e. the newest producer, wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      hit[p] = 1'b0;
      fwd[p] = 32'd0;
      if (rn[p] != 5'd0) begin
        if (write_q && wn_q == rn[p]) begin
          hit[p] = 1'b1;
          fwd[p] = wd_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          idx = rd_ptr_q + PW'(i);
          if (CW'(i) < count_q && fifo_dst_q[idx] == rn[p]) begin
            hit[p] = 1'b1;
            fwd[p] = fifo_dat_q[idx];
          end
        end
      end
    end
  end

  assign Hit1 = hit[0];
  assign Hit2 = hit[1];
  assign Fwd1 = fwd[0];
  assign Fwd2 = fwd[1];
`else
  logic unused_rn;
  assign unused_rn = ^{Rn1, Rn2};
  assign Hit1 = 1'b0;
  assign Hit2 = 1'b0;
  assign Fwd1 = 32'd0;
  assign Fwd2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single write latency, ALU/MEM fairness,
// mid-fill reset, dst-0 discard, back-to-back burst and register bypass.
module tb_wb_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        AluValid = 1'b0;
  logic        AluReady;
  logic [4:0]  AluDst = 5'd0;
  logic [31:0] AluData = 32'd0;
  logic        MemValid = 1'b0;
  logic        MemReady;
  logic [4:0]  MemDst = 5'd0;
  logic [31:0] MemData = 32'd0;
  logic        Write;
  logic [4:0]  Wn;
  logic [31:0] Wd;
  logic [4:0]  Rn1 = 5'd0;
  logic [4:0]  Rn2 = 5'd0;
  logic        Hit1, Hit2;
  logic [31:0] Fwd1, Fwd2;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_arbiter #(.DEPTH(4)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .AluValid(AluValid), .AluReady(AluReady), .AluDst(AluDst), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemDst(MemDst), .MemData(MemData),
    .Write(Write), .Wn(Wn), .Wd(Wd),
    .Rn1(Rn1), .Rn2(Rn2), .Hit1(Hit1), .Hit2(Hit2), .Fwd1(Fwd1), .Fwd2(Fwd2)
  );

  always #5 Clock = ~Clock;

  // Step to 1ns after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    tick();
    tick();
    n_checks++; if ({Write, Wn, Wd} !== 38'd0) $display("FAIL reset_wport: got %b/%0d/%h want 0/0/0", Write, Wn, Wd); else n_pass++;
    n_checks++; if (dut.count_q !== 3'd0) $display("FAIL reset_count: got %0d want 0", dut.count_q); else n_pass++;
    Resetn = 1'b1;
    #1;
    n_checks++; if ({AluReady, MemReady} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {AluReady, MemReady}); else n_pass++;
    n_checks++; if ({Hit1, Hit2} !== 2'b00) $display("FAIL reset_hit: got %b want 00", {Hit1, Hit2}); else n_pass++;
  endtask

  task automatic test_single();
    AluValid = 1'b1; AluDst = 5'd5; AluData = 32'hDEADBEEF;
    #1;
    n_checks++; if (AluReady !== 1'b1) $display("FAIL single_ready: got %b want 1", AluReady); else n_pass++;
    tick();
    AluValid = 1'b0; AluDst = 5'd0; AluData = 32'd0;
    #1;
    n_checks++; if (Write !== 1'b0) $display("FAIL single_early: got %b want 0", Write); else n_pass++;
    tick();
    n_checks++; if ({Write, Wn, Wd} !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("FAIL single_write: got %b/%0d/%h want 1/5/deadbeef", Write, Wn, Wd); else n_pass++;
    tick();
    n_checks++; if ({Write, Wn, Wd} !== {1'b0, 5'd5, 32'hDEADBEEF}) $display("FAIL single_after: got %b/%0d/%h want 0/5/deadbeef", Write, Wn, Wd); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [4:0]  exp_dst [8];
    logic [31:0] exp_dat [8];
    logic        is_mem;
    AluValid = 1'b1; AluDst = 5'd1;
    MemValid = 1'b1; MemDst = 5'd2;
    for (int i = 0; i < 8; i++) begin
      AluData = 32'hA000_0000 + 32'(i);
      MemData = 32'hB000_0000 + 32'(i);
      #1;
      is_mem = ((i % 4) == 3);
      exp_dst[i] = is_mem ? 5'd2 : 5'd1;
      exp_dat[i] = is_mem ? 32'hB000_0000 + 32'(i) : 32'hA000_0000 + 32'(i);
      n_checks++; if ({AluReady, MemReady} !== {!is_mem, is_mem}) $display("FAIL fair_ready%0d: got %b want %b", i, {AluReady, MemReady}, {!is_mem, is_mem}); else n_pass++;
      tick();
      if (i > 0) begin
        n_checks++; if ({Write, Wn, Wd} !== {1'b1, exp_dst[i-1], exp_dat[i-1]}) $display("FAIL fair_write%0d: got %b/%0d/%h want 1/%0d/%h", i-1, Write, Wn, Wd, exp_dst[i-1], exp_dat[i-1]); else n_pass++;
      end
    end
    AluValid = 1'b0; MemValid = 1'b0;
    tick();
    n_checks++; if ({Write, Wn, Wd} !== {1'b1, exp_dst[7], exp_dat[7]}) $display("FAIL fair_write7: got %b/%0d/%h want 1/%0d/%h", Write, Wn, Wd, exp_dst[7], exp_dat[7]); else n_pass++;
    tick();
    n_checks++; if (Write !== 1'b0) $display("FAIL fair_drain: got %b want 0", Write); else n_pass++;
  endtask

  task automatic test_reset_mid();
    AluValid = 1'b1;
    AluDst = 5'd3; AluData = 32'h33; tick();
    AluDst = 5'd4; AluData = 32'h44; tick();
    AluDst = 5'd6; AluData = 32'h66; tick();
    n_checks++; if ({Write, Wn} !== {1'b1, 5'd4}) $display("FAIL rmid_pre: got %b/%0d want 1/4", Write, Wn); else n_pass++;
    Resetn = 1'b0; AluValid = 1'b0;
    #1;
    n_checks++; if ({Write, Wn, Wd} !== 38'd0) $display("FAIL rmid_async: got %b/%0d/%h want 0/0/0", Write, Wn, Wd); else n_pass++;
    n_checks++; if (dut.count_q !== 3'd0) $display("FAIL rmid_count: got %0d want 0", dut.count_q); else n_pass++;
    tick();
    tick();
    // Release and present a new word at once: the first high edge must accept it.
    Resetn = 1'b1; AluValid = 1'b1; AluDst = 5'd9; AluData = 32'h99;
    #1;
    n_checks++; if (AluReady !== 1'b1) $display("FAIL rmid_ready: got %b want 1", AluReady); else n_pass++;
    tick();
    AluValid = 1'b0;
    n_checks++; if (Write !== 1'b0) $display("FAIL rmid_stale: got %b want 0", Write); else n_pass++;
    n_checks++; if (dut.count_q !== 3'd1) $display("FAIL rmid_count1: got %0d want 1", dut.count_q); else n_pass++;
    tick();
    n_checks++; if ({Write, Wn, Wd} !== {1'b1, 5'd9, 32'h99}) $display("FAIL rmid_first: got %b/%0d/%h want 1/9/99", Write, Wn, Wd); else n_pass++;
    tick();
  endtask

  task automatic test_dst_zero();
    logic seen;
    AluValid = 1'b1; AluDst = 5'd0; AluData = 32'h1234;
    #1;
    n_checks++; if (AluReady !== 1'b1) $display("FAIL dst0_ready: got %b want 1", AluReady); else n_pass++;
    tick();
    AluValid = 1'b0;
    #1;
    n_checks++; if (dut.count_q !== 3'd0) $display("FAIL dst0_count: got %0d want 0", dut.count_q); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (Write === 1'b1) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL dst0_write: got %b want 0", seen); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      AluValid = 1'b1; AluDst = 5'(10 + i); AluData = 32'h100 + 32'(i);
      #1;
      n_checks++; if (AluReady !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, AluReady); else n_pass++;
      tick();
      if (i == 0) begin
        n_checks++; if (Write !== 1'b0) $display("FAIL b2b_lead: got %b want 0", Write); else n_pass++;
      end else begin
        n_checks++; if ({Write, Wn, Wd} !== {1'b1, 5'(9 + i), 32'hFF + 32'(i)}) $display("FAIL b2b_write%0d: got %b/%0d/%h want 1/%0d/%h", i-1, Write, Wn, Wd, 9 + i, 32'hFF + 32'(i)); else n_pass++;
      end
    end
    AluValid = 1'b0;
    tick();
    n_checks++; if ({Write, Wn, Wd} !== {1'b1, 5'd15, 32'h105}) $display("FAIL b2b_write5: got %b/%0d/%h want 1/15/105", Write, Wn, Wd); else n_pass++;
    tick();
    n_checks++; if (Write !== 1'b0) $display("FAIL b2b_tail: got %b want 0", Write); else n_pass++;
  endtask

  task automatic test_bypass();
    Rn1 = 5'd7; Rn2 = 5'd0;
    AluValid = 1'b1; AluDst = 5'd7; AluData = 32'h11;
    tick();
    AluData = 32'h22;
    tick();
    AluValid = 1'b0;
    #1;
    // Beat carries 0x11, queue holds the newer 0x22.
    n_checks++; if ({Hit1, Fwd1} !== {BYP, BYP ? 32'h22 : 32'h0}) $display("FAIL byp_q_hit1: got %b/%h want %b/%h", Hit1, Fwd1, BYP, BYP ? 32'h22 : 32'h0); else n_pass++;
    n_checks++; if ({Hit2, Fwd2} !== 33'd0) $display("FAIL byp_rn0: got %b/%h want 0/0", Hit2, Fwd2); else n_pass++;
    tick();
    Rn2 = 5'd7;
    #1;
    n_checks++; if ({Hit1, Fwd1} !== {BYP, BYP ? 32'h22 : 32'h0}) $display("FAIL byp_beat_hit1: got %b/%h want %b/%h", Hit1, Fwd1, BYP, BYP ? 32'h22 : 32'h0); else n_pass++;
    n_checks++; if ({Hit2, Fwd2} !== {BYP, BYP ? 32'h22 : 32'h0}) $display("FAIL byp_beat_hit2: got %b/%h want %b/%h", Hit2, Fwd2, BYP, BYP ? 32'h22 : 32'h0); else n_pass++;
    tick();
    n_checks++; if ({Hit1, Hit2} !== 2'b00) $display("FAIL byp_empty: got %b want 00", {Hit1, Hit2}); else n_pass++;
    Rn1 = 5'd0; Rn2 = 5'd0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_reset_mid();
    test_dst_zero();
    test_back_to_back();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning write-queue entries (power of two, 2..16).
REQ-002 SHALL have port Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports AluValid input 1, AluReady output 1, AluDst input 5, AluData input 32: ALU result source.
REQ-005 SHALL have ports MemValid input 1, MemReady output 1, MemDst input 5, MemData input 32: load-unit result source.
REQ-006 SHALL have ports Write output 1, Wn output 5, Wd output 32: register-file write port (write enable, destination, data).
REQ-007 SHALL have ports Rn1, Rn2 input 5 (query registers); Hit1, Hit2 output 1; Fwd1, Fwd2 output 32 (bypass results).

Function
REQ-008 SHALL transfer a source word on a rising edge where Valid and Ready are both high; no transfer otherwise.
REQ-009 SHALL hold both Ready outputs low when the queue holds DEPTH entries, even if a pop occurs in the same cycle.
REQ-010 SHALL accept at most one source word per cycle; when not full, ALU wins by default: AluReady = not full; MemReady = not full and (AluValid low or MEM-priority active).
REQ-011 SHALL keep a 2-bit streak counter: +1 each edge ALU transfers while MemValid high; cleared on MEM transfer or MemValid low; saturates at 3.
REQ-012 SHALL activate MEM priority while streak = 3: MemReady = not full, AluReady = not full and MemValid low.
REQ-013 SHALL accept and discard words with Dst = 0 (handshake completes, nothing queued, count unchanged).
REQ-014 SHALL queue accepted words in FIFO order, count 0..DEPTH, pointers wrapping modulo DEPTH.
REQ-015 SHALL pop one entry per edge when count > 0 and register it: Write=1, Wn=dst, Wd=data for the following cycle; Write=0 (Wn/Wd hold) when empty.
REQ-016 SHALL give latency: word accepted into an empty queue at edge k appears on Write/Wn/Wd after edge k+1.
REQ-017 SHALL allow push and pop on the same edge when not full; count unchanged.
REQ-018 SHALL never emit Write=1 with Wn=0.

Reset
REQ-019 SHALL, while Resetn low, asynchronously force Write=0, Wn=0, Wd=0, count=0, pointers=0, streak=0; queued entries discarded.
REQ-020 SHALL drive AluReady and MemReady from the empty queue immediately after reset deassertion (AluReady=1).
REQ-021 SHALL treat reset mid-operation identically: no partial write after Resetn rises; first transfer on first edge with Resetn high.

Configuration
REQ-022 SHALL use macro WB_BYPASS_EN to compile bypass logic in or out.
REQ-023 SHALL, with WB_BYPASS_EN defined, set HitN=1 and FwdN=data of the newest queued entry or current Write/Wn/Wd beat whose dst equals RnN (newest wins; RnN=0 never hits), combinationally.
REQ-024 SHALL, without WB_BYPASS_EN, tie Hit1/Hit2=0 and Fwd1/Fwd2=0; all other behaviour identical.

Verification
REQ-025 SHALL cover: reset, AluValid=1 AluDst=5 AluData=0xDEADBEEF one cycle -> after 2 edges Write=1 Wn=5 Wd=0xDEADBEEF for exactly one cycle.
REQ-026 SHALL cover: both sources valid continuously (ALU dst 1, MEM dst 2), sink draining -> accepts ALU,ALU,ALU,MEM repeating; no MEM starvation.
REQ-027 SHALL cover: DEPTH=4, Resetn cycling mid-fill after 3 accepts -> Write=0 immediately, no stale write after release, count restarts 0.
REQ-028 SHALL cover: AluDst=0 with AluData=0x1234 -> handshake completes, Write never asserted.
REQ-029 SHALL cover: fill 4 entries without draining stalled? (n/a: drain constant) -> burst of 6 back-to-back ALU words -> all 6 appear in order, Write high 6 consecutive cycles.
REQ-030 SHALL cover (WB_BYPASS_EN): queue dst 7 = 0x11 then dst 7 = 0x22, Rn1=7 -> Hit1=1 Fwd1=0x22; Rn2=0 -> Hit2=0; without macro Hit1=0.
